// File: rtl/mips_pkg.sv
// Shared constants and types for the 5-stage MIPS core front end.
// No logic: parameters, opcode encodings and the IF/ID payload struct.
// No flow control of its own.
package mips_pkg;

    localparam int          DATA_W        = 32;
    localparam logic [31:0] RESET_PC      = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;
    localparam int          PC_INC        = 4;

    localparam logic [5:0]  OP_RTYPE      = 6'h00;
    localparam logic [5:0]  OP_J          = 6'h02;
    localparam logic [5:0]  OP_JAL        = 6'h03;
    localparam logic [5:0]  OP_BEQ        = 6'h04;
    localparam logic [5:0]  OP_BNE        = 6'h05;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] pc_plus4;
        logic              valid;
    } ifid_t;

endpackage

// File: rtl/pc_register.sv
// Program counter with next-PC select: stall > taken branch > jump > PC+4.
// Latency: new PC visible one edge after the selecting inputs.
// Backpressure: stall freezes the PC; redirects presented during a stall are dropped.
module pc_register #(
    parameter int                DATA_W   = mips_pkg::DATA_W,
    parameter logic [DATA_W-1:0] RESET_PC = mips_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              pc_src,
    input  logic [DATA_W-1:0] branch_target,
    input  logic              jump,
    input  logic [DATA_W-1:0] jump_target,
    output logic [DATA_W-1:0] pc_q,
    output logic [DATA_W-1:0] pc_plus4
);
    import mips_pkg::*;

    // Targets are forced word-aligned; the low two bits carry no meaning.
    localparam logic [DATA_W-1:0] ALIGN_MASK = {{(DATA_W-2){1'b1}}, 2'b00};

    logic [DATA_W-1:0] pc_d;

    assign pc_plus4 = pc_q + DATA_W'(PC_INC);

    always_comb begin
        pc_d = pc_plus4;
        if (stall) begin
            pc_d = pc_q;
        end else if (pc_src) begin
            pc_d = branch_target & ALIGN_MASK;
        end else if (jump) begin
            pc_d = jump_target & ALIGN_MASK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/if_id_fetch_stage.sv
// Fetch stage + IF/ID register; optional perf counters under `IF_ID_PERF_CNT_EN.
// Latency: imem_addr is the PC combinationally; the fetched word reaches ID one edge later.
// Backpressure: stall holds PC and IF/ID; flush turns the IF/ID entry into a bubble.
module if_id_fetch_stage #(
    parameter int                DATA_W   = mips_pkg::DATA_W,
    parameter logic [DATA_W-1:0] RESET_PC = mips_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              pc_src,
    input  logic [DATA_W-1:0] branch_target,
    input  logic              jump,
    input  logic [DATA_W-1:0] jump_target,
    output logic [DATA_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] pc_o,
    output logic [DATA_W-1:0] instr_id,
    output logic [DATA_W-1:0] pc_plus4_id,
    output logic              valid_id
`ifdef IF_ID_PERF_CNT_EN
   ,output logic [31:0]       flush_cnt,
    output logic [31:0]       stall_cnt
`endif
);
    import mips_pkg::*;

    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] pc_plus4;
    ifid_t             ifid_q;
    ifid_t             ifid_d;

    pc_register #(
        .DATA_W   (DATA_W),
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .pc_q          (pc_q),
        .pc_plus4      (pc_plus4)
    );

    assign imem_addr = pc_q;
    assign pc_o      = pc_q;

    // A flush coinciding with a stall is dropped: the stalled entry must survive.
    always_comb begin
        ifid_d = '{instr: imem_rdata, pc_plus4: pc_plus4, valid: 1'b1};
        if (stall) begin
            ifid_d = ifid_q;
        end else if (flush) begin
            ifid_d = '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_q <= '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign instr_id    = ifid_q.instr;
    assign pc_plus4_id = ifid_q.pc_plus4;
    assign valid_id    = ifid_q.valid;

`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        flush_cnt_d = flush_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (flush && !stall) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
        if (stall) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            flush_cnt_q <= flush_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign flush_cnt = flush_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    // Counters are not built; nothing else depends on them.
`endif

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Directed bench for if_id_fetch_stage; imem is a combinational address-derived pattern.
module tb_if_id_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, pc_src, jump;
    logic [31:0] branch_target, jump_target;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] pc_o, instr_id, pc_plus4_id;
    logic        valid_id;
`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] flush_cnt, stall_cnt;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    assign imem_rdata = word_at(imem_addr);

    if_id_fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .flush         (flush),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .pc_o          (pc_o),
        .instr_id      (instr_id),
        .pc_plus4_id   (pc_plus4_id),
        .valid_id      (valid_id)
`ifdef IF_ID_PERF_CNT_EN
       ,.flush_cnt     (flush_cnt),
        .stall_cnt     (stall_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        stall = 0; flush = 0; pc_src = 0; jump = 0;
        branch_target = 32'h0; jump_target = 32'h0;
    endtask

    task automatic test_reset();
        clear_ctrl();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        step();
        flush = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (pc_o !== 32'h0040_0000) begin
            tests_failed++; $display("FAIL reset_pc: got %h expected %h", pc_o, 32'h0040_0000);
        end
        tests_run++;
        if (imem_addr !== 32'h0040_0000) begin
            tests_failed++; $display("FAIL reset_imem_addr: got %h expected %h", imem_addr, 32'h0040_0000);
        end
        tests_run++;
        if (instr_id !== 32'h0 || valid_id !== 1'b0 || pc_plus4_id !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_ifid: got instr=%h v=%b p4=%h expected 0/0/0", instr_id, valid_id, pc_plus4_id);
        end
`ifdef IF_ID_PERF_CNT_EN
        tests_run++;
        if (flush_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
            tests_failed++; $display("FAIL reset_cnt: got f=%0d s=%0d expected 0/0", flush_cnt, stall_cnt);
        end
`endif
        @(negedge clk);
        clear_ctrl();
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        step();
        tests_run++;
        if (pc_o !== 32'h0040_0004 || instr_id !== word_at(32'h0040_0000)) begin
            tests_failed++;
            $display("FAIL seq_first: got pc=%h instr=%h expected %h %h",
                     pc_o, instr_id, 32'h0040_0004, word_at(32'h0040_0000));
        end
        step();
        step();
        tests_run++;
        if (pc_o !== 32'h0040_000C) begin
            tests_failed++; $display("FAIL seq_pc: got %h expected %h", pc_o, 32'h0040_000C);
        end
        tests_run++;
        if (instr_id !== word_at(32'h0040_0008) || pc_plus4_id !== 32'h0040_000C || valid_id !== 1'b1) begin
            tests_failed++;
            $display("FAIL seq_ifid: got instr=%h p4=%h v=%b expected %h %h 1",
                     instr_id, pc_plus4_id, valid_id, word_at(32'h0040_0008), 32'h0040_000C);
        end
    endtask

    task automatic test_taken_branch();
        pc_src = 1; flush = 1; branch_target = 32'h0040_0100;
        step();
        clear_ctrl();
        tests_run++;
        if (pc_o !== 32'h0040_0100) begin
            tests_failed++; $display("FAIL branch_pc: got %h expected %h", pc_o, 32'h0040_0100);
        end
        tests_run++;
        if (instr_id !== 32'h0 || valid_id !== 1'b0 || pc_plus4_id !== 32'h0) begin
            tests_failed++;
            $display("FAIL branch_bubble: got instr=%h v=%b p4=%h expected 0/0/0", instr_id, valid_id, pc_plus4_id);
        end
        step();
        tests_run++;
        if (instr_id !== word_at(32'h0040_0100) || pc_plus4_id !== 32'h0040_0104 || valid_id !== 1'b1) begin
            tests_failed++;
            $display("FAIL branch_target_ifid: got instr=%h p4=%h v=%b expected %h %h 1",
                     instr_id, pc_plus4_id, valid_id, word_at(32'h0040_0100), 32'h0040_0104);
        end
`ifdef IF_ID_PERF_CNT_EN
        tests_run++;
        if (flush_cnt !== 32'd1) begin
            tests_failed++; $display("FAIL branch_flush_cnt: got %0d expected 1", flush_cnt);
        end
`endif
    endtask

    task automatic test_flush_only();
        flush = 1;
        step();
        clear_ctrl();
        tests_run++;
        if (pc_o !== 32'h0040_0108 || valid_id !== 1'b0 || instr_id !== 32'h0) begin
            tests_failed++;
            $display("FAIL flush_only: got pc=%h v=%b instr=%h expected %h 0 0", pc_o, valid_id, instr_id, 32'h0040_0108);
        end
        step();
        tests_run++;
        if (instr_id !== word_at(32'h0040_0108) || pc_plus4_id !== 32'h0040_010C || valid_id !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_recover: got instr=%h p4=%h v=%b expected %h %h 1",
                     instr_id, pc_plus4_id, valid_id, word_at(32'h0040_0108), 32'h0040_010C);
        end
    endtask

    task automatic test_stall_priority();
        stall = 1; flush = 1; pc_src = 1; jump = 1;
        branch_target = 32'h0040_0500; jump_target = 32'h0040_0600;
        step();
        step();
        clear_ctrl();
        tests_run++;
        if (pc_o !== 32'h0040_010C) begin
            tests_failed++; $display("FAIL stall_pc: got %h expected %h", pc_o, 32'h0040_010C);
        end
        tests_run++;
        if (instr_id !== word_at(32'h0040_0108) || pc_plus4_id !== 32'h0040_010C || valid_id !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_ifid: got instr=%h p4=%h v=%b expected %h %h 1",
                     instr_id, pc_plus4_id, valid_id, word_at(32'h0040_0108), 32'h0040_010C);
        end
`ifdef IF_ID_PERF_CNT_EN
        tests_run++;
        if (flush_cnt !== 32'd2 || stall_cnt !== 32'd2) begin
            tests_failed++; $display("FAIL stall_cnt: got f=%0d s=%0d expected 2/2", flush_cnt, stall_cnt);
        end
`endif
    endtask

    task automatic test_jump_wrap();
        jump = 1; jump_target = 32'h0040_0203;
        step();
        clear_ctrl();
        tests_run++;
        if (pc_o !== 32'h0040_0200) begin
            tests_failed++; $display("FAIL jump_pc: got %h expected %h", pc_o, 32'h0040_0200);
        end
        tests_run++;
        if (instr_id !== word_at(32'h0040_010C) || pc_plus4_id !== 32'h0040_0110 || valid_id !== 1'b1) begin
            tests_failed++;
            $display("FAIL jump_delay_slot: got instr=%h p4=%h v=%b expected %h %h 1",
                     instr_id, pc_plus4_id, valid_id, word_at(32'h0040_010C), 32'h0040_0110);
        end
        pc_src = 1; jump = 1; branch_target = 32'h0040_0300; jump_target = 32'h0040_0400;
        step();
        clear_ctrl();
        tests_run++;
        if (pc_o !== 32'h0040_0300) begin
            tests_failed++; $display("FAIL branch_over_jump: got %h expected %h", pc_o, 32'h0040_0300);
        end
        jump = 1; jump_target = 32'hFFFF_FFFC;
        step();
        clear_ctrl();
        tests_run++;
        if (pc_o !== 32'hFFFF_FFFC) begin
            tests_failed++; $display("FAIL jump_top: got %h expected %h", pc_o, 32'hFFFF_FFFC);
        end
        step();
        tests_run++;
        if (pc_o !== 32'h0 || pc_plus4_id !== 32'h0) begin
            tests_failed++; $display("FAIL wrap: got pc=%h p4=%h expected 0 0", pc_o, pc_plus4_id);
        end
        tests_run++;
        if (instr_id !== word_at(32'hFFFF_FFFC) || valid_id !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_instr: got instr=%h v=%b expected %h 1", instr_id, valid_id, word_at(32'hFFFF_FFFC));
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_taken_branch();
        test_flush_only();
        test_stall_priority();
        test_jump_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
